// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one-hot-zero column drive, synchronised and debounced rows, key-code FIFO on a bus window.
// Scan FSM advances only on tick; rd_data is registered one clk after rd_en; full FIFO drops codes and sets overflow.
module keypad_scan_ctrl #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);
  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DT       = CW'(DEBOUNCE_TICKS);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_sync, r_rs, r_cols;
  logic [1:0]    r_col_idx, r_row, w_col_nxt, w_row_nxt, w_low_row;
  logic [CW-1:0] r_ctr, w_ctr_nxt, w_ctr_inc;
  logic          w_any, w_same, w_push;
  logic [3:0]    w_push_code;

  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic          r_ovf;
  logic [31:0]   r_rd_data;
  logic [7:0]    w_count8;
  logic          w_empty, w_full, w_pop, w_flush, w_clr_ovf, w_push_ok;
  logic          w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 4'hF;
      r_rs   <= 4'hF;
    end else begin
      r_sync <= rows;
      r_rs   <= r_sync;
    end
  end

  always_comb begin
    w_low_row = 2'd0;
    if      (!r_rs[0]) w_low_row = 2'd0;
    else if (!r_rs[1]) w_low_row = 2'd1;
    else if (!r_rs[2]) w_low_row = 2'd2;
    else if (!r_rs[3]) w_low_row = 2'd3;
  end

  assign w_any     = (r_rs != 4'hF);
  assign w_same    = w_any && (w_low_row == r_row);
  assign w_ctr_inc = r_ctr + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_SCAN;
      r_col_idx <= 2'd0;
      r_row     <= 2'd0;
      r_ctr     <= '0;
      r_cols    <= 4'b1110;
    end else begin
      r_state   <= w_state_nxt;
      r_col_idx <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_ctr     <= w_ctr_nxt;
      r_cols    <= ~(4'b0001 << w_col_nxt);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (tick) begin
      case (r_state)
        S_SCAN:     if (w_any) w_state_nxt = (DEBOUNCE_TICKS == 1) ? S_HELD : S_DEBOUNCE;
        S_DEBOUNCE: if (!w_same) w_state_nxt = S_SCAN;
                    else if (w_ctr_inc == DT) w_state_nxt = S_HELD;
        S_HELD:     if (!w_any && (w_ctr_inc == DT)) w_state_nxt = S_SCAN;
        default:    w_state_nxt = S_SCAN;
      endcase
    end
  end

  // Columns stay parked on the pressed key through DEBOUNCE and HELD, so rs only ever shows that column.
  always_comb begin
    w_push      = 1'b0;
    w_col_nxt   = r_col_idx;
    w_row_nxt   = r_row;
    w_ctr_nxt   = r_ctr;
    w_push_code = (r_state == S_SCAN) ? {w_low_row, r_col_idx} : {r_row, r_col_idx};
    if (tick) begin
      case (r_state)
        S_SCAN: begin
          if (w_any) begin
            w_row_nxt = w_low_row;
            w_push    = (DEBOUNCE_TICKS == 1);
            w_ctr_nxt = (DEBOUNCE_TICKS == 1) ? '0 : CW'(1);
          end else begin
            w_col_nxt = r_col_idx + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (!w_same) begin
            w_col_nxt = r_col_idx + 2'd1;
            w_ctr_nxt = '0;
          end else if (w_ctr_inc == DT) begin
            w_push    = 1'b1;
            w_ctr_nxt = '0;
          end else begin
            w_ctr_nxt = w_ctr_inc;
          end
        end
        S_HELD: begin
          if (w_any) begin
            w_ctr_nxt = '0;
          end else if (w_ctr_inc == DT) begin
            w_ctr_nxt = '0;
            w_col_nxt = r_col_idx + 2'd1;
          end else begin
            w_ctr_nxt = w_ctr_inc;
          end
        end
        default: w_ctr_nxt = '0;
      endcase
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = rd_en && (addr == 2'd0) && !w_empty;
  assign w_flush   = wr_en && (addr == 2'd2) && wr_data[1];
  assign w_clr_ovf = wr_en && (addr == 2'd2) && wr_data[0];
  // A same-clk pop frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_push && (!w_full || w_pop) && !w_flush;
  assign w_count8  = 8'(r_count);
  assign w_unused  = &{1'b0, wr_data[31:2]};

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= w_push_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + PW'(1);
        if (w_pop)     r_rptr <= r_rptr + PW'(1);
        if (w_push_ok && !w_pop)      r_count <= r_count + (PW+1)'(1);
        else if (w_pop && !w_push_ok) r_count <= r_count - (PW+1)'(1);
      end
      if (w_push && w_full && !w_pop && !w_flush) r_ovf <= 1'b1;
      else if (w_clr_ovf)                         r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      case (addr)
        2'd0:    r_rd_data <= w_empty ? 32'd0 : {27'd0, 1'b1, r_mem[r_rptr]};
        2'd1:    r_rd_data <= {16'd0, w_count8, 5'd0, r_ovf, w_full, w_empty};
        default: r_rd_data <= 32'd0;
      endcase
    end
  end

  assign cols    = r_cols;
  assign rd_data = r_rd_data;
  assign irq     = !w_empty;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model closes the column/row loop, a queue models the key-code FIFO.
module tb_keypad_scan_ctrl;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        irq;

  logic [15:0] key_dn = '0;
  logic [3:0]  model_q[$];
  logic        model_ovf = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  keypad_scan_ctrl #(.DEBOUNCE_TICKS(3), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rows(rows), .cols(cols),
    .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .irq(irq)
  );

  always #5 clk = ~clk;

  // Key k = row*4+col pulls its row low whenever its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_dn[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Rows settle for three clks before each strobe, covering the two-flop synchroniser.
  task automatic do_tick(input bit with_pop = 1'b0);
    repeat (3) @(negedge clk);
    tick = 1'b1;
    if (with_pop) begin
      rd_en = 1'b1;
      addr  = 2'd0;
    end
    @(negedge clk);
    tick  = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_en = 1'b1;
    addr  = a;
    @(negedge clk);
    rd_en = 1'b0;
    d     = rd_data;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    wr_en   = 1'b1;
    addr    = a;
    wr_data = v;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  function automatic logic [31:0] exp_status();
    logic [7:0] n;
    n = 8'(model_q.size());
    return {16'h0, n, 5'b0, model_ovf, model_q.size() == DEPTH, model_q.size() == 0};
  endfunction

  task automatic model_push(input logic [3:0] code);
    if (model_q.size() < DEPTH) model_q.push_back(code);
    else model_ovf = 1'b1;
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    bus_rd(2'd1, d);
    chk(tag, d, exp_status());
  endtask

  task automatic chk_data(input string tag);
    logic [31:0] d, e;
    e = 32'd0;
    if (model_q.size() > 0) e = {27'd0, 1'b1, model_q.pop_front()};
    bus_rd(2'd0, d);
    chk(tag, d, e);
  endtask

  task automatic align_col(input int c);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << c);
    n   = 0;
    while (cols != tgt && n < 8) begin
      do_tick();
      n++;
    end
    chk("align_col", {28'd0, cols}, {28'd0, tgt});
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    key_dn[code] = 1'b1;
    repeat (hold) do_tick();
    key_dn = '0;
    repeat (5) do_tick();
    model_push(code);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  head;
    logic [3:0]  codes4 [9] = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd1, 4'd6, 4'd11, 4'd12, 4'd7};

    // Reset with strobes running
    repeat (3) do_tick();
    chk("rst_cols", {28'd0, cols}, 32'h0000_000E);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_status("rst_status");

    // Clean press row2/col1
    align_col(1);
    key_dn[9] = 1'b1;
    do_tick();
    do_tick();
    chk("press_irq_early", {31'd0, irq}, 32'd0);
    do_tick();
    model_push(4'd9);
    chk("press_irq", {31'd0, irq}, 32'd1);
    bus_rd(2'd0, d);
    chk("press_data", d, 32'h0000_0019);
    void'(model_q.pop_front());
    chk_status("press_empty");
    repeat (20) do_tick();
    chk_status("hold_no_repeat");
    key_dn = '0;
    repeat (5) do_tick();

    // Bounce on row0/col3: low 2, high 1, low 3, then held; release bounces in HELD
    align_col(3);
    key_dn[3] = 1'b1; repeat (2) do_tick();
    key_dn[3] = 1'b0; do_tick();
    chk_status("bounce_no_push");
    key_dn[3] = 1'b1; repeat (11) do_tick();
    key_dn[3] = 1'b0; do_tick();
    key_dn[3] = 1'b1; do_tick();
    key_dn[3] = 1'b0; repeat (2) do_tick();
    key_dn[3] = 1'b1; do_tick();
    key_dn[3] = 1'b0; repeat (5) do_tick();
    model_push(4'd3);
    chk_status("bounce_one_push");
    chk_data("bounce_data");
    chk_status("bounce_empty");

    // Overflow with nine presses and no reads
    for (int i = 0; i < 9; i++) press(codes4[i], 8);
    chk_status("ovf_status");
    chk("ovf_irq", {31'd0, irq}, 32'd1);
    bus_rd(2'd2, d);
    chk("ctrl_rd_zero", d, 32'd0);
    chk_status("ovf_status2");
    bus_rd(2'd3, d);
    chk("addr3_rd_zero", d, 32'd0);
    bus_wr(2'd0, 32'hFFFF_FFFF);
    chk_status("data_wr_ignored");
    for (int i = 0; i < 9; i++) chk_data("drain");

    // Push and pop in the same clk with the FIFO full
    bus_wr(2'd2, 32'h1);
    model_ovf = 1'b0;
    chk_status("ovf_cleared");
    for (int i = 0; i < DEPTH; i++) press(4'($urandom_range(0, 15)), 8);
    align_col(2);
    key_dn[14] = 1'b1;
    do_tick();
    do_tick();
    do_tick(1'b1);
    head = model_q.pop_front();
    model_push(4'd14);
    chk("pushpop_data", rd_data, {27'd0, 1'b1, head});
    chk_status("pushpop_status");
    key_dn = '0;
    repeat (5) do_tick();
    press(4'd0, 8);
    chk_status("refull_ovf");
    bus_wr(2'd2, 32'h3);
    model_q.delete();
    model_ovf = 1'b0;
    chk_status("flush_status");
    chk("flush_irq", {31'd0, irq}, 32'd0);

    // Reset two ticks into debounce; key stays down across reset
    align_col(2);
    key_dn[6] = 1'b1;
    do_tick();
    do_tick();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cols", {28'd0, cols}, 32'h0000_000E);
    rst_n = 1'b1;
    chk_status("midrst_empty");
    repeat (10) do_tick();
    key_dn = '0;
    repeat (5) do_tick();
    model_push(4'd6);
    chk_status("midrst_one");
    chk_data("midrst_data");
    chk_status("midrst_empty2");

    // Random presses with random register reads
    for (int i = 0; i < 30; i++) begin
      int sel;
      press(4'($urandom_range(0, 15)), int'($urandom_range(8, 11)));
      sel = int'($urandom_range(0, 3));
      if (sel < 2) chk_data("rand_data");
      else if (sel == 2) chk_status("rand_status");
    end
    chk_status("rand_final_status");
    for (int i = 0; i < DEPTH + 1; i++) chk_data("rand_drain");
    chk_status("rand_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1);
  end
endmodule
